adc_serial_emu: RTL and testbench
=================================

ADC_SERIAL_EMU -- requirements
Module: adc_serial_emu

Interface
REQ-001 SHALL take parameter BUSY_CYCLES, default 20, giving conversion time in CLK cycles (legal range 2..255).
REQ-002 SHALL take parameter DW, default 18, giving sample width in bits (fixed at 18 for the AD7643 emulation).
REQ-003 SHALL have port CLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RSTN, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port CNVST, input, 1, conversion start from the controller; the falling edge starts a conversion.
REQ-006 SHALL have port SCLK, input, 1, serial clock from the controller.
REQ-007 SHALL have port CS, input, 1, active-low chip select.
REQ-008 SHALL have port PATSEL, input, 2, sample pattern select.
REQ-009 SHALL have port SEED, input, 18, pattern seed or constant value.
REQ-010 SHALL have port SDOUT, output, 1, serial data, MSB first.
REQ-011 SHALL have port BUSY, output, 1, high while a conversion is in progress.
REQ-012 SHALL have port CONVCNT, output, 16, count of completed conversions.

Function
REQ-013 SHALL pass CNVST, SCLK and CS each through a 2-FF synchronizer; edges SHALL be detected on the synchronized copies, giving 3 CLK cycles of input-to-action latency.
REQ-014 SHALL require an SCLK high or low phase of at least 4 CLK cycles; behaviour at faster SCLK is undefined.
REQ-015 SHALL implement states IDLE, CONV, READY and SHIFT.
REQ-016 IDLE or READY: a detected CNVST falling edge SHALL load the busy counter with BUSY_CYCLES-1, set BUSY=1 and go to CONV.
REQ-017 CONV: the busy counter SHALL decrement each cycle; CNVST edges SHALL be ignored.
REQ-018 CONV, at counter=0, SHALL do all of the following in the same cycle:
- generate the next sample;
- load the 18-bit shift register;
- set BUSY=0;
- increment CONVCNT, wrapping 65535->0;
- go to READY.
REQ-019 In READY or SHIFT, SDOUT SHALL equal shift-register bit 17 while synced CS=0, and SHALL be 0 while synced CS=1.
REQ-020 Each detected SCLK falling edge with synced CS=0 SHALL shift the register left by 1 (filling with 0), increment the bit counter and go to SHIFT; the controller samples on SCLK rising edges.
REQ-021 The 18th such falling edge SHALL clear the bit counter and go to IDLE with SDOUT=0.
REQ-022 SCLK edges SHALL be ignored in IDLE and CONV.
REQ-023 A CNVST falling edge in SHIFT SHALL abort the readout: the remaining bits are dropped, the bit counter is cleared, and REQ-016 applies.
REQ-024 PATSEL=00, ramp: the first sample after reset SHALL be SEED, and each following sample the previous sample +1 mod 2^18.
REQ-025 PATSEL=01, constant: every sample SHALL be SEED.
REQ-026 PATSEL=10, LFSR: the sample SHALL be an 18-bit Fibonacci LFSR, x^18+x^11+1, shifted left with feedback into bit 0, advanced once per conversion.
REQ-027 The LFSR state after reset SHALL be SEED, or 18'h00001 when SEED=0.
REQ-028 PATSEL=11, alternating: samples SHALL be SEED, ~SEED, SEED, ... with the phase toggling each conversion.
REQ-029 PATSEL and SEED SHALL be sampled only at sample generation; a PATSEL change mid-stream SHALL continue from the current ramp, LFSR and phase state.

Reset
REQ-030 While RSTN=0 at a CLK edge, the block SHALL reset as follows:
- state=IDLE;
- BUSY=0, SDOUT=0, CONVCNT=0;
- bit counter=0, shift register=0;
- ramp and LFSR "first sample" flags set; alternate phase=0;
- all synchronizers set to 1 (idle-high).
REQ-031 Reset mid-conversion or mid-readout SHALL abandon the operation with no CONVCNT increment.
REQ-032 The first CLK after RSTN rises SHALL NOT detect a false CNVST edge.

Verification
REQ-033 BUSY_CYCLES=20, PATSEL=01, SEED=18'h2AAAA; CNVST falls -> BUSY rises 3 cycles later, stays high 20 cycles; then 18 SCLK periods with CS=0 read back 18'h2AAAA; CONVCNT=1.
REQ-034 PATSEL=00, SEED=18'h3FFFE; 3 conversions -> reads 18'h3FFFE, 18'h3FFFF, 18'h00000.
REQ-035 PATSEL=10, SEED=0; 2 conversions -> reads 18'h00002, 18'h00004.
REQ-036 CNVST pulse again during CONV -> ignored, single BUSY pulse, CONVCNT +1 only.
REQ-037 CNVST after 5 shifted bits -> abort, new BUSY pulse, next readout is the new sample from MSB.
REQ-038 RSTN low for 1 cycle during SHIFT -> SDOUT=0, BUSY=0, CONVCNT=0, state IDLE; no spurious conversion afterwards.

Source files
------------

// File: rtl/adc_serial_emu.sv
// AD7643-style 18-bit ADC emulator: a CNVST falling edge starts a BUSY conversion, then an SPI-like MSB-first readout.
// All controller inputs pass 2-FF synchronizers, so actions follow 3 CLK after an input edge; SCLK phases must be >= 4 CLK.
module adc_serial_emu #(
  parameter int BUSY_CYCLES = 20,
  parameter int DW          = 18
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CNVST,
  input  logic          SCLK,
  input  logic          CS,
  input  logic [1:0]    PATSEL,
  input  logic [DW-1:0] SEED,
  output logic          SDOUT,
  output logic          BUSY,
  output logic [15:0]   CONVCNT
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, READY = 2'd2, SHIFT = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnv_sync_q, sclk_sync_q, cs_sync_q;
  logic [7:0]    busy_cnt_q, busy_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [DW-1:0] ramp_q, ramp_d, lfsr_q, lfsr_d;
  logic          ramp_first_q, ramp_first_d, lfsr_first_q, lfsr_first_d;
  logic          alt_q, alt_d;
  logic [15:0]   convcnt_q, convcnt_d;

  logic          cnv_fall, sclk_fall, cs_low, start_conv, shift_en, last_bit, readable;
  logic [DW-1:0] ramp_next, lfsr_base, lfsr_next, sample;

  // Bit 1 is the synchronized copy; bit 2 is its previous value for edge detection.
  assign cnv_fall   = cnv_sync_q[2] & ~cnv_sync_q[1];
  assign sclk_fall  = sclk_sync_q[2] & ~sclk_sync_q[1];
  assign cs_low     = ~cs_sync_q[1];
  assign readable   = (state_q == READY) || (state_q == SHIFT);
  assign start_conv = cnv_fall && (state_q != CONV);
  assign shift_en   = readable && sclk_fall && cs_low && !cnv_fall;
  assign last_bit   = (bit_cnt_q == 5'(DW-1));

  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (cnv_fall) state_d = CONV;
      CONV:        if (busy_cnt_q == '0) state_d = READY;
      READY, SHIFT: begin
        if (cnv_fall)      state_d = CONV;
        else if (shift_en) state_d = last_bit ? IDLE : SHIFT;
      end
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY  = (state_q == CONV);
    SDOUT = readable && cs_low && shreg_q[DW-1];
  end

  // Each pattern keeps its own history, so switching PATSEL resumes where that pattern left off.
  always_comb begin
    ramp_next = ramp_first_q ? SEED : ramp_q + DW'(1);
    lfsr_base = !lfsr_first_q ? lfsr_q : ((SEED == '0) ? DW'(1) : SEED);
    lfsr_next = {lfsr_base[DW-2:0], lfsr_base[DW-1] ^ lfsr_base[10]};
    case (PATSEL)
      2'b00:   sample = ramp_next;
      2'b01:   sample = SEED;
      2'b10:   sample = lfsr_next;
      default: sample = alt_q ? ~SEED : SEED;
    endcase
  end

  always_comb begin
    busy_cnt_d   = busy_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    convcnt_d    = convcnt_q;
    ramp_d       = ramp_q;
    ramp_first_d = ramp_first_q;
    lfsr_d       = lfsr_q;
    lfsr_first_d = lfsr_first_q;
    alt_d        = alt_q;
    if (start_conv) begin
      busy_cnt_d = 8'(BUSY_CYCLES - 1);
      bit_cnt_d  = '0;
    end else if (state_q == CONV) begin
      if (busy_cnt_q != '0) begin
        busy_cnt_d = busy_cnt_q - 8'd1;
      end else begin
        shreg_d   = sample;
        convcnt_d = convcnt_q + 16'd1;
        case (PATSEL)
          2'b00: begin ramp_d = ramp_next; ramp_first_d = 1'b0; end
          2'b10: begin lfsr_d = lfsr_next; lfsr_first_d = 1'b0; end
          2'b11: alt_d = ~alt_q;
          default: ;
        endcase
      end
    end else if (shift_en) begin
      shreg_d   = {shreg_q[DW-2:0], 1'b0};
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnv_sync_q   <= 3'b111;
      sclk_sync_q  <= 3'b111;
      cs_sync_q    <= 3'b111;
      busy_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      convcnt_q    <= '0;
      ramp_q       <= '0;
      ramp_first_q <= 1'b1;
      lfsr_q       <= '0;
      lfsr_first_q <= 1'b1;
      alt_q        <= 1'b0;
    end else begin
      cnv_sync_q   <= {cnv_sync_q[1:0], CNVST};
      sclk_sync_q  <= {sclk_sync_q[1:0], SCLK};
      cs_sync_q    <= {cs_sync_q[1:0], CS};
      busy_cnt_q   <= busy_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      convcnt_q    <= convcnt_d;
      ramp_q       <= ramp_d;
      ramp_first_q <= ramp_first_d;
      lfsr_q       <= lfsr_d;
      lfsr_first_q <= lfsr_first_d;
      alt_q        <= alt_d;
    end
  end

  assign CONVCNT = convcnt_q;

endmodule

// File: tb/tb_adc_serial_emu.sv
// Bench for adc_serial_emu: directed scenarios plus random conversions, readouts and aborts.
// Expected samples are queued at conversion start; a monitor assembles SDOUT bits and compares on readout end.
module tb_adc_serial_emu;
  localparam int BC = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cnvst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic [1:0]  patsel = 2'b01;
  logic [17:0] seed = '0;
  logic        sdout, busy;
  logic [15:0] convcnt;

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];
  int unsigned conv_model = 0;

  // Reference pattern state
  int unsigned m_ramp, m_lfsr;
  bit m_ramp_first, m_lfsr_first, m_alt;

  logic [17:0] mon_word = '0;
  int mon_n = 0;

  adc_serial_emu #(.BUSY_CYCLES(BC), .DW(18)) dut (
    .CLK(clk), .RSTN(rstn), .CNVST(cnvst), .SCLK(sclk), .CS(cs),
    .PATSEL(patsel), .SEED(seed), .SDOUT(sdout), .BUSY(busy), .CONVCNT(convcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ramp = 0; m_lfsr = 0;
    m_ramp_first = 1'b1; m_lfsr_first = 1'b1; m_alt = 1'b0;
    conv_model = 0;
  endfunction

  function automatic logic [17:0] model_next(input logic [1:0] ps, input logic [17:0] sd);
    int unsigned s, fb;
    logic [17:0] r;
    r = sd;
    case (ps)
      2'd0: begin
        if (m_ramp_first) m_ramp = 32'(sd);
        else              m_ramp = (m_ramp + 1) % 262144;
        m_ramp_first = 1'b0;
        r = 18'(m_ramp);
      end
      2'd1: r = sd;
      2'd2: begin
        if (!m_lfsr_first) s = m_lfsr;
        else if (sd == 0)  s = 1;
        else               s = 32'(sd);
        fb = ((s >> 17) ^ (s >> 10)) & 1;
        m_lfsr = (s * 2) % 262144 + fb;
        m_lfsr_first = 1'b0;
        r = 18'(m_lfsr);
      end
      default: begin
        r = m_alt ? ~sd : sd;
        m_alt = !m_alt;
      end
    endcase
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts a conversion and checks BUSY latency, width and the completion count.
  task automatic start_conv(input logic [1:0] ps, input logic [17:0] sd, input bit directed,
                            input logic [17:0] dexp, input bit extra);
    logic [17:0] m;
    int n, h;
    patsel = ps;
    seed = sd;
    m = model_next(ps, sd);
    exp_q.push_back(directed ? dexp : m);
    conv_model++;
    @(negedge clk);
    cnvst = 1'b0;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check("busy_rise_latency", n, 3);
    h = 0;
    while (busy && h < BC + 10) begin
      h++;
      @(negedge clk);
      if (h == 2) cnvst = 1'b1;
      if (extra && h == 8) cnvst = 1'b0;
      if (extra && h == 12) cnvst = 1'b1;
    end
    cnvst = 1'b1;
    check("busy_width", h, BC);
    check("convcnt", convcnt, conv_model % 65536);
  endtask

  task automatic read_bits(input int nbits);
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
      tick(5);
    end
  endtask

  task automatic cs_release();
    cs = 1'b1;
    tick(4);
  endtask

  task automatic mon_close();
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      check("readout_unexpected", mon_n, 0);
    end else begin
      e = exp_q.pop_front();
      if (mon_n == 18) check("readout", mon_word, e);
      else             check("readout_partial", mon_word, e >> (18 - mon_n));
    end
    mon_n = 0;
    mon_word = '0;
  endtask

  // Controller-side monitor: samples SDOUT on SCLK rising edges while CS is low.
  always @(posedge sclk or posedge cs) begin
    if (cs) begin
      if (mon_n != 0) mon_close();
    end else begin
      mon_word = {mon_word[16:0], sdout};
      mon_n++;
      if (mon_n == 18) mon_close();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ps;
    logic [17:0] sd;
    bit ex, ab;
    int nb;

    model_reset();
    tick(3);
    rstn = 1'b1;
    tick(1);
    check("reset_sdout", sdout, 0);
    check("reset_busy", busy, 0);
    check("reset_convcnt", convcnt, 0);
    tick(5);
    check("no_false_cnvst", busy, 0);

    // Constant pattern, full readout
    start_conv(2'b01, 18'h2AAAA, 1'b1, 18'h2AAAA, 1'b0);
    read_bits(18); cs_release();

    // Ramp wrapping through 2^18
    start_conv(2'b00, 18'h3FFFE, 1'b1, 18'h3FFFE, 1'b0); read_bits(18); cs_release();
    start_conv(2'b00, 18'h3FFFE, 1'b1, 18'h3FFFF, 1'b0); read_bits(18); cs_release();
    start_conv(2'b00, 18'h3FFFE, 1'b1, 18'h00000, 1'b0); read_bits(18); cs_release();

    // LFSR with zero seed starts from 1
    start_conv(2'b10, 18'h00000, 1'b1, 18'h00002, 1'b0); read_bits(18); cs_release();
    start_conv(2'b10, 18'h00000, 1'b1, 18'h00004, 1'b0); read_bits(18); cs_release();

    // Extra CNVST pulse while converting is ignored
    start_conv(2'b01, 18'h12345, 1'b1, 18'h12345, 1'b1); read_bits(18); cs_release();

    // Alternating pattern, abort after 5 bits, then full read of the new sample
    start_conv(2'b11, 18'h0F0F0, 1'b1, 18'h0F0F0, 1'b0);
    read_bits(5);
    cs = 1'b1;
    start_conv(2'b11, 18'h0F0F0, 1'b1, 18'h30F0F, 1'b0);
    read_bits(18); cs_release();

    for (int it = 0; it < 24; it++) begin
      ps = 2'($urandom_range(0, 3));
      sd = 18'($urandom);
      ex = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 3) == 0);
      start_conv(ps, sd, 1'b0, 18'h0, ex);
      if (ab) begin
        nb = $urandom_range(1, 17);
        read_bits(nb);
        cs = 1'b1;
      end else begin
        read_bits(18);
        cs_release();
      end
    end

    // Reset pulse in the middle of a readout
    start_conv(2'b01, 18'h3C3C3, 1'b1, 18'h3C3C3, 1'b0);
    read_bits(7);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    model_reset();
    check("midshift_reset_sdout", sdout, 0);
    check("midshift_reset_busy", busy, 0);
    check("midshift_reset_convcnt", convcnt, 0);
    cs = 1'b1;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check("no_spurious_conversion", nb, 0);

    // First ramp sample after reset is SEED again
    sd = 18'($urandom);
    start_conv(2'b00, sd, 1'b0, 18'h0, 1'b0);
    read_bits(18); cs_release();

    tick(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
